lsu_mem: RTL
============

Name: lsu_mem

Overview:
- Memory-stage load/store unit of the RV32 pipeline.
- Takes a load/store request from the EX/MEM latch and drives a single-outstanding data-memory port with a valid/ready request and valid response.
- Aligns and sign/zero-extends load data and presents it as io_wb_mem to the writeback select stage.
- Stalls the pipeline while a transaction is in flight and flags misaligned or illegal accesses.

Parameters:
- None. Datapath is fixed at 32 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- io_req_valid  in  1  memory instruction present in MEM stage
- io_req_fcn  in  1  0 = load, 1 = store
- io_req_typ  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- io_req_addr  in  32  byte address
- io_req_wdata  in  32  store data (rs2)
- io_dmem_req_valid  out  1  request to data memory
- io_dmem_req_ready  in  1  memory accepts request
- io_dmem_addr  out  32  word address ({addr[31:2],2'b00})
- io_dmem_wen  out  1  1 = write
- io_dmem_wmask  out  4  byte enables
- io_dmem_wdata  out  32  lane-replicated store data
- io_dmem_resp_valid  in  1  read data valid
- io_dmem_resp_rdata  in  32  read word
- io_stall  out  1  hold pipeline
- io_done  out  1  one-cycle pulse: access complete
- io_xcpt  out  1  misaligned/illegal access
- io_wb_mem  out  32  extended load result

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset: returns to IDLE; all outputs 0; io_wb_mem = 0.
- Reset mid-transaction: abandon it and go to IDLE; a later io_dmem_resp_valid is ignored.
- Exception (xcpt) condition, evaluated combinationally in IDLE with io_req_valid:
  - halfword with addr[0] != 0;
  - word with addr[1:0] != 0;
  - typ in {011, 110, 111};
  - typ 100/101 with fcn = 1.
- On xcpt: io_xcpt = 1, no memory request, io_stall = 0, state stays IDLE.
- IDLE:
  - Legal io_req_valid: latch fcn/typ/addr/wdata, io_stall = 1 the same cycle, go to REQ.
  - No request: io_stall = 0.
- REQ:
  - io_dmem_req_valid = 1; addr, wen, wmask, wdata driven from latched fields; io_stall = 1.
  - If io_dmem_req_ready: store goes to DONE, load goes to WAIT.
  - Otherwise stay in REQ with outputs held stable.
- WAIT:
  - io_stall = 1.
  - On io_dmem_resp_valid: io_wb_mem <= extended data, go to DONE.
  - io_dmem_resp_valid is ignored in every other state.
- DONE:
  - io_done = 1, io_stall = 0 (pipeline advances at this edge), go to IDLE.
  - io_req_valid is ignored in DONE: the same instruction is still present.
- Latency, zero-wait memory (ready = 1, response the next cycle):
  - store: 2 stall cycles;
  - load: 3 stall cycles, io_wb_mem valid in the DONE cycle.
- Store masks and data (a = addr[1:0]):
  - SB: wmask = 1 << a, wdata = {4{wdata[7:0]}};
  - SH: wmask = a[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}};
  - SW: wmask = 1111, wdata unchanged.
- Loads never assert wen; wmask = 0000 for loads.
- Load extraction: shifted = rdata >> (8*a).
  - LB: sign-extend shifted[7:0]; LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0]; LHU: zero-extend shifted[15:0].
  - LW: rdata unchanged.
- io_wb_mem holds its value until the next load completes; stores and exceptions leave it unchanged.
- Back-to-back: a new request is accepted in the first IDLE cycle after DONE.

Test Plan:
- LB, addr 0x103, rdata 0x80FF_1234, ready = 1, resp after 1 cycle -> io_dmem_addr 0x100; io_wb_mem 0xFFFF_FF80 in DONE; io_stall high exactly 3 cycles; io_done 1 cycle.
- LHU, addr 0x202, rdata 0xBEEF_0000 -> io_wb_mem 0x0000_BEEF; LH, same address and rdata -> io_wb_mem 0xFFFF_BEEF.
- SB, addr 0x11, wdata 0x0000_00AB, ready low 3 cycles then high -> io_dmem_req_valid held 4 cycles; wmask 0010; wdata 0xABAB_ABAB; wen 1; io_wb_mem unchanged; then DONE.
- SW, addr 0x6 -> io_xcpt 1 in the same cycle; no io_dmem_req_valid; io_stall 0. typ 011 -> io_xcpt 1.
- LW, addr 0x40, reset asserted in WAIT, resp_valid arrives after reset with 0x1234_5678 -> state IDLE; io_wb_mem stays 0; no io_done.
- LW, then SW back-to-back with io_req_valid held through DONE -> exactly two dmem requests; second accepted in the cycle after the first io_done.

Source files
------------

// File: rtl/lsu_mem.sv
// RV32 memory-stage load/store unit.
// Single-outstanding dmem port, load alignment/extension, misalign traps.
module lsu_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_req_valid,
  input  logic        io_req_fcn,
  input  logic [2:0]  io_req_typ,
  input  logic [31:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  output logic        io_dmem_req_valid,
  input  logic        io_dmem_req_ready,
  output logic [31:0] io_dmem_addr,
  output logic        io_dmem_wen,
  output logic [3:0]  io_dmem_wmask,
  output logic [31:0] io_dmem_wdata,
  input  logic        io_dmem_resp_valid,
  input  logic [31:0] io_dmem_resp_rdata,
  output logic        io_stall,
  output logic        io_done,
  output logic        io_xcpt,
  output logic [31:0] io_wb_mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  logic        fcn_q;
  logic [2:0]  typ_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wb_q;

  logic        bad;
  logic        xcpt;
  logic        accept;
  logic [3:0]  mask;
  logic [31:0] sdata;
  logic [31:0] shifted;
  logic [31:0] ext;

  always_comb begin
    bad = 1'b0;
    unique case (io_req_typ)
      3'b000: bad = 1'b0;
      3'b001: bad = io_req_addr[0];
      3'b010: bad = |io_req_addr[1:0];
      3'b100: bad = io_req_fcn;
      3'b101: bad = io_req_fcn | io_req_addr[0];
      default: bad = 1'b1;
    endcase
  end

  assign xcpt   = !reset && state == IDLE && io_req_valid && bad;
  assign accept = !reset && state == IDLE && io_req_valid && !bad;

  always_comb begin
    mask  = 4'b0000;
    sdata = wdata_q;
    unique case (typ_q[1:0])
      2'b00: begin
        mask  = 4'b0001 << addr_q[1:0];
        sdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        mask  = addr_q[1] ? 4'b1100 : 4'b0011;
        sdata = {2{wdata_q[15:0]}};
      end
      default: begin
        mask  = 4'b1111;
        sdata = wdata_q;
      end
    endcase
    if (!fcn_q)
      mask = 4'b0000;
  end

  // Byte lane selection: bring the addressed byte/half to bit 0.
  assign shifted = io_dmem_resp_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ext = io_dmem_resp_rdata;
    unique case (typ_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = io_dmem_resp_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      fcn_q   <= 1'b0;
      typ_q   <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wb_q    <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            fcn_q   <= io_req_fcn;
            typ_q   <= io_req_typ;
            addr_q  <= io_req_addr;
            wdata_q <= io_req_wdata;
            state   <= REQ;
          end
        end
        REQ: begin
          if (io_dmem_req_ready)
            state <= fcn_q ? DONE : WAIT;
        end
        WAIT: begin
          if (io_dmem_resp_valid) begin
            wb_q  <= ext;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic in_req;
  assign in_req = !reset && state == REQ;

  assign io_dmem_req_valid = in_req;
  assign io_dmem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign io_dmem_wen   = in_req && fcn_q;
  assign io_dmem_wmask = in_req ? mask : 4'b0000;
  assign io_dmem_wdata = in_req ? sdata : 32'h0;

  assign io_stall = accept || in_req || (!reset && state == WAIT);
  assign io_done  = !reset && state == DONE;
  assign io_xcpt  = xcpt;
  assign io_wb_mem = wb_q;

endmodule
